iq_binner: RTL and testbench
============================

IQ_BINNER -- requirements
Module: iq_binner

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of each histogram bin counter.
REQ-002 SHALL have parameter BIN_AW, default 5, index width per axis; memory holds 2^(2*BIN_AW) bins.
REQ-003 SHALL have ports: clk100  in  1  sole clock.
REQ-004 SHALL have ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: iq_valid  in  1  one-cycle pulse; i_val/q_val valid.
REQ-006 SHALL have ports: i_val, q_val  in  32 each  signed integrated I/Q.
REQ-007 SHALL have ports: x_bin_min, y_bin_min  in  16 each  signed bin origin.
REQ-008 SHALL have ports: x_bin_width, y_bin_width  in  16 each  unsigned bin width.
REQ-009 SHALL have ports: x_bin_num, y_bin_num  in  5 each  bins per axis.
REQ-010 SHALL have ports: clear  in  1  pulse; zero all bins.
REQ-011 SHALL have ports: rd_req  in  1; rd_addr  in  10 = {y_idx, x_idx}.
REQ-012 SHALL have ports: rd_valid  out  1; rd_data  out  COUNT_W.
REQ-013 SHALL have ports: busy  out  1; drop_count  out  16; oor_count  out  16.

Function
REQ-014 SHALL implement FSM states CLEAR, IDLE, CALC, INCR.
REQ-015 SHALL, in IDLE with iq_valid=1, latch i_val, q_val and all bin config, then enter CALC.
REQ-016 SHALL compute offset = value - sign-extended bin_min at 33 bits; a negative offset is out of range.
REQ-017 SHALL derive the index by repeated subtraction of width, one step per cycle per axis, with both axes in parallel; it SHALL stop when offset < width, and the index SHALL equal the step count.
REQ-018 SHALL treat index >= bin_num, width == 0, or bin_num == 0 as out of range without iterating.
REQ-019 SHALL, in INCR, read-modify-write bin {y_idx, x_idx}, saturating at all-ones, then return to IDLE.
REQ-020 SHALL make an out-of-range event skip INCR, increment oor_count (saturating), and return to IDLE.
REQ-021 SHALL give total latency from iq_valid to count visible of at most max(x_idx, y_idx) + 3 cycles.
REQ-022 SHALL assert busy in every state except IDLE.
REQ-023 SHALL drop an iq_valid arriving while busy and increment drop_count (saturating).
REQ-024 SHALL, when clear and iq_valid coincide in IDLE, let clear win and count the event as dropped.
REQ-025 SHALL, on clear, enter CLEAR, write zero to one address per cycle for 1024 cycles, and zero drop_count and oor_count.
REQ-026 SHALL return rd_data with rd_valid=1 exactly one cycle after rd_req, in any state.
REQ-027 SHALL, on a read of the address written in the same cycle, return the pre-write value.

Reset
REQ-028 SHALL, with reset_n low, asynchronously force rd_valid=0, rd_data=0, drop_count=0, oor_count=0, and busy=1.
REQ-029 SHALL enter CLEAR on reset_n release, because memory contents are not reset directly.
REQ-030 SHALL, if reset_n is asserted mid-CALC/INCR, abandon the event without modifying the bin.

Configuration
REQ-031 SHALL, with macro IQ_BINNER_OOR_COUNT_EN defined, implement the oor_count counter as specified.
REQ-032 SHALL, without IQ_BINNER_OOR_COUNT_EN, tie oor_count to 0, silently discard out-of-range events, and synthesize no counter logic.

Structure
REQ-033 SHALL take the FSM state enum, bin address typedef (10 bits), and CLEAR_LEN=1024 from shared package qubit_pkg.
REQ-034 SHALL implement the per-axis iterative index computation as sub-module bin_index_calc, instantiated twice.

Verification
REQ-035 SHALL verify: after reset release, busy stays high 1024 cycles, then every rd_addr reads 0.
REQ-036 SHALL verify: min=0, width=100, num=10, i=250, q=930 -> bin {9,2} = 1, busy low within 12 cycles.
REQ-037 SHALL verify: i=-5 with x_bin_min=0 -> no bin changes and oor_count=1 (with macro) or 0 (without).
REQ-038 SHALL verify: a second iq_valid 2 cycles after the first -> drop_count=1 and only one bin incremented.
REQ-039 SHALL verify: 65536 hits on bin {0,0} -> rd_data=16'hFFFF, no wrap.
REQ-040 SHALL verify: reset_n pulsed low mid-CALC -> target bin remains 0 after the re-clear.

Source files
------------

// File: rtl/qubit_pkg.sv
// Shared types and constants for the IQ histogram binner.
//   CLEAR_LEN  : number of histogram bins wiped by one clear sweep
//   bin_addr_t : histogram bin address {y_idx, x_idx}
//   state_t    : binner sequencer states
//   sat_inc16  : 16-bit saturating increment used by the event counters
package qubit_pkg;

  localparam int CLEAR_LEN = 1024;
  localparam int ADDR_W    = 10;

  typedef logic [ADDR_W-1:0] bin_addr_t;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    CALC  = 2'd2,
    INCR  = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bin_index_calc.sv
// Per-axis bin index search. On start it latches the sample and the axis
// configuration, then subtracts the bin width once per cycle until the
// remaining offset drops below the width. The index is the number of
// subtractions performed.
// Ports:
//   clk100, reset_n      : clock, async active-low reset
//   start                : load value/config and begin a search
//   value                : signed 32-bit sample
//   bin_min, bin_width   : signed axis origin, unsigned bin width
//   bin_num              : number of bins on this axis
//   done                 : search finished (held until the next start)
//   oor                  : sample falls outside the axis range
//   idx                  : bin index, valid when done && !oor
module bin_index_calc #(
  parameter int IDX_W = 5
) (
  input  logic             clk100,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      value,
  input  logic [15:0]      bin_min,
  input  logic [15:0]      bin_width,
  input  logic [4:0]       bin_num,
  output logic             done,
  output logic             oor,
  output logic [IDX_W-1:0] idx
);

  logic [32:0]      off_q, off_d;
  logic [15:0]      width_q, width_d;
  logic [4:0]       num_q, num_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             oor_q, oor_d;

  logic [32:0] width_ext;
  logic [5:0]  idx_inc;
  logic        bad, hit, last;

  always_comb begin
    width_ext = {17'd0, width_q};
    idx_inc   = 6'(idx_q) + 6'd1;
    // Negative offset, zero width or zero bins can never land in a bin.
    bad       = off_q[32] || (width_q == 16'd0) || (num_q == 5'd0);
    hit       = !bad && (off_q < width_ext);
    // Another subtraction would push the index past the last bin.
    last      = idx_inc >= {1'b0, num_q};

    off_d   = off_q;
    width_d = width_q;
    num_d   = num_q;
    idx_d   = idx_q;
    run_d   = run_q;
    done_d  = done_q;
    oor_d   = oor_q;

    if (start) begin
      off_d   = {value[31], value} - {{17{bin_min[15]}}, bin_min};
      width_d = bin_width;
      num_d   = bin_num;
      idx_d   = '0;
      run_d   = 1'b1;
      done_d  = 1'b0;
      oor_d   = 1'b0;
    end else if (run_q) begin
      if (bad || hit || last) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        oor_d  = !hit;
      end else begin
        off_d = off_q - width_ext;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      off_q   <= '0;
      width_q <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      off_q   <= off_d;
      width_q <= width_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      done_q  <= done_d;
      oor_q   <= oor_d;
    end
  end

  assign done = done_q;
  assign oor  = oor_q;
  assign idx  = idx_q;

endmodule

// File: rtl/iq_binner.sv
// 2-D histogram of integrated I/Q samples. Each accepted sample is mapped to
// a bin {y_idx, x_idx} and that bin's counter is incremented (saturating).
// Optional macro IQ_BINNER_OOR_COUNT_EN enables the out-of-range counter;
// without it oor_count is tied to zero and out-of-range samples are dropped.
// Ports:
//   clk100, reset_n          : clock, async active-low reset
//   iq_valid, i_val, q_val   : sample strobe and signed I/Q values
//   x/y_bin_min, _width, _num: per-axis histogram configuration
//   clear                    : wipe all bins and the event counters
//   rd_req, rd_addr          : bin read port, rd_addr = {y_idx, x_idx}
//   rd_valid, rd_data        : read response, one cycle after rd_req
//   busy                     : high whenever a new sample cannot be taken
//   drop_count, oor_count    : saturating event counters
//
// state | meaning
// CLEAR | sweeping zeros through every bin (after reset or clear)
// IDLE  | waiting for iq_valid
// CALC  | both axis index searches running
// INCR  | read-modify-write of the selected bin
module iq_binner
  import qubit_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int BIN_AW  = 5
) (
  input  logic               clk100,
  input  logic               reset_n,
  input  logic               iq_valid,
  input  logic [31:0]        i_val,
  input  logic [31:0]        q_val,
  input  logic [15:0]        x_bin_min,
  input  logic [15:0]        y_bin_min,
  input  logic [15:0]        x_bin_width,
  input  logic [15:0]        y_bin_width,
  input  logic [4:0]         x_bin_num,
  input  logic [4:0]         y_bin_num,
  input  logic               clear,
  input  logic               rd_req,
  input  logic [9:0]         rd_addr,
  output logic               rd_valid,
  output logic [COUNT_W-1:0] rd_data,
  output logic               busy,
  output logic [15:0]        drop_count,
  output logic [15:0]        oor_count
);

  state_t             state_q, state_d;
  bin_addr_t          clr_cnt_q, clr_cnt_d;
  logic               busy_q, busy_d;
  logic               rd_valid_q, rd_valid_d;
  logic [COUNT_W-1:0] rd_data_q, rd_data_d;
  logic [15:0]        drop_q, drop_d;

  logic [COUNT_W-1:0] mem [CLEAR_LEN];
  logic               mem_we;
  bin_addr_t          mem_waddr;
  logic [COUNT_W-1:0] mem_wdata;
  logic [COUNT_W-1:0] bin_cur;

  logic              start;
  logic              x_done, y_done, x_oor, y_oor;
  logic [BIN_AW-1:0] x_idx, y_idx;
  bin_addr_t         bin_addr;

  assign start    = (state_q == IDLE) && iq_valid && !clear;
  assign bin_addr = bin_addr_t'({y_idx, x_idx});
  assign bin_cur  = mem[bin_addr];

  bin_index_calc #(.IDX_W(BIN_AW)) u_x_calc (
    .clk100    (clk100),
    .reset_n   (reset_n),
    .start     (start),
    .value     (i_val),
    .bin_min   (x_bin_min),
    .bin_width (x_bin_width),
    .bin_num   (x_bin_num),
    .done      (x_done),
    .oor       (x_oor),
    .idx       (x_idx)
  );

  bin_index_calc #(.IDX_W(BIN_AW)) u_y_calc (
    .clk100    (clk100),
    .reset_n   (reset_n),
    .start     (start),
    .value     (q_val),
    .bin_min   (y_bin_min),
    .bin_width (y_bin_width),
    .bin_num   (y_bin_num),
    .done      (y_done),
    .oor       (y_oor),
    .idx       (y_idx)
  );

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    drop_d     = drop_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_cnt_q;
    mem_wdata  = '0;
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? mem[rd_addr] : rd_data_q;

    if (iq_valid && ((state_q != IDLE) || clear)) begin
      drop_d = sat_inc16(drop_q);
    end

    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        if (clr_cnt_q == '0) state_d = IDLE;
        else                 clr_cnt_d = clr_cnt_q - ADDR_W'(1);
      end
      IDLE: begin
        if (start) state_d = CALC;
      end
      CALC: begin
        if (x_done && y_done) state_d = (x_oor || y_oor) ? IDLE : INCR;
      end
      INCR: begin
        mem_we    = 1'b1;
        mem_waddr = bin_addr;
        mem_wdata = (&bin_cur) ? bin_cur : bin_cur + COUNT_W'(1);
        state_d   = IDLE;
      end
      default: state_d = CLEAR;
    endcase

    // clear overrides everything; a coincident sample counts as the first drop.
    if (clear) begin
      state_d   = CLEAR;
      clr_cnt_d = ADDR_W'(CLEAR_LEN - 1);
      drop_d    = iq_valid ? 16'd1 : 16'd0;
    end

    busy_d = (state_d != IDLE);
  end

`ifdef IQ_BINNER_OOR_COUNT_EN
  logic [15:0] oor_q, oor_d;
  logic        oor_evt;

  assign oor_evt = (state_q == CALC) && x_done && y_done && (x_oor || y_oor);

  always_comb begin
    oor_d = oor_q;
    if (clear)        oor_d = '0;
    else if (oor_evt) oor_d = sat_inc16(oor_q);
  end

  assign oor_count = oor_q;
`else
  assign oor_count = 16'd0;
`endif

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= ADDR_W'(CLEAR_LEN - 1);
      busy_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      drop_q     <= '0;
`ifdef IQ_BINNER_OOR_COUNT_EN
      oor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      drop_q     <= drop_d;
`ifdef IQ_BINNER_OOR_COUNT_EN
      oor_q      <= oor_d;
`endif
    end
  end

  // Bin storage has no reset; the CLEAR sweep after reset initialises it.
  always_ff @(posedge clk100) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy       = busy_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_iq_binner.sv
module tb_iq_binner;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic        reset_n, iq_valid, clear, rd_req;
  logic [31:0] i_val, q_val;
  logic [15:0] x_bin_min, y_bin_min, x_bin_width, y_bin_width;
  logic [4:0]  x_bin_num, y_bin_num;
  logic [9:0]  rd_addr;

  logic        rd_valid, busy;
  logic [15:0] rd_data, drop_count, oor_count;
  logic        n_rd_valid, n_busy;
  logic [3:0]  n_rd_data;
  logic [15:0] n_drop_count, n_oor_count;

  iq_binner dut (
    .clk100(clk100), .reset_n(reset_n), .iq_valid(iq_valid),
    .i_val(i_val), .q_val(q_val),
    .x_bin_min(x_bin_min), .y_bin_min(y_bin_min),
    .x_bin_width(x_bin_width), .y_bin_width(y_bin_width),
    .x_bin_num(x_bin_num), .y_bin_num(y_bin_num),
    .clear(clear), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .drop_count(drop_count), .oor_count(oor_count)
  );

  // Narrow-counter copy on the same stimulus: saturation reachable in a few hits.
  iq_binner #(.COUNT_W(4), .BIN_AW(5)) dut_narrow (
    .clk100(clk100), .reset_n(reset_n), .iq_valid(iq_valid),
    .i_val(i_val), .q_val(q_val),
    .x_bin_min(x_bin_min), .y_bin_min(y_bin_min),
    .x_bin_width(x_bin_width), .y_bin_width(y_bin_width),
    .x_bin_num(x_bin_num), .y_bin_num(y_bin_num),
    .clear(clear), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(n_rd_valid), .rd_data(n_rd_data), .busy(n_busy),
    .drop_count(n_drop_count), .oor_count(n_oor_count)
  );

  typedef struct { int addr; int data; } rd_exp_t;
  typedef struct {
    int i; int q; int xmin; int ymin; int xw; int yw; int xn; int yn;
    bit in_rng; int ex; int ey;
  } vec_t;

  rd_exp_t sb_q[$];
  rd_exp_t mon_e;
  vec_t    vecs [12];
  int      model [1024];
  int      checks = 0;
  int      errors = 0;
  int      exp_drop = 0;
  int      exp_oor = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk100) begin
    if (reset_n && rd_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: rd_valid with no pending read, data %0d", rd_data);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("rd_bin[%0d]", mon_e.addr), {16'd0, rd_data}, mon_e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget, output int cnt);
    cnt = 0;
    while (busy && cnt < budget) begin
      tick(1);
      cnt++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic set_cfg(input vec_t v);
    i_val       = v.i;
    q_val       = v.q;
    x_bin_min   = 16'(v.xmin);
    y_bin_min   = 16'(v.ymin);
    x_bin_width = 16'(v.xw);
    y_bin_width = 16'(v.yw);
    x_bin_num   = 5'(v.xn);
    y_bin_num   = 5'(v.yn);
  endtask

  task automatic send(input vec_t v, input string name, output int cnt);
    set_cfg(v);
    iq_valid = 1'b1;
    tick(1);
    iq_valid = 1'b0;
    wait_idle(name, 80, cnt);
  endtask

  task automatic read_bin(input int a);
    sb_q.push_back('{a, model[a]});
    rd_req  = 1'b1;
    rd_addr = 10'(a);
    tick(1);
    rd_req  = 1'b0;
    tick(1);
  endtask

  task automatic read_all();
    for (int a = 0; a < 1024; a++) begin
      sb_q.push_back('{a, model[a]});
      rd_req  = 1'b1;
      rd_addr = 10'(a);
      tick(1);
    end
    rd_req = 1'b0;
    tick(2);
  endtask

  task automatic read_narrow(input int a, input int exp);
    sb_q.push_back('{a, model[a]});
    rd_req  = 1'b1;
    rd_addr = 10'(a);
    tick(1);
    rd_req  = 1'b0;
    @(negedge clk100);
    check("narrow_rd_valid", {31'd0, n_rd_valid}, 32'd1);
    check("narrow_saturate", {28'd0, n_rd_data}, exp);
    check("narrow_busy", {31'd0, n_busy}, 32'd0);
    check("narrow_drop", {16'd0, n_drop_count}, exp_drop);
    check("narrow_oor", {16'd0, n_oor_count}, exp_oor);
    tick(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   cnt, bound, addr;
    vec_t v;

    vecs[0]  = '{250, 930, 0, 0, 100, 100, 10, 10, 1'b1, 2, 9};
    vecs[1]  = '{-5, 10, 0, 0, 100, 100, 10, 10, 1'b0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 100, 100, 10, 10, 1'b1, 0, 0};
    vecs[3]  = '{99, 100, 0, 0, 100, 100, 10, 10, 1'b1, 0, 1};
    vecs[4]  = '{1000, 0, 0, 0, 100, 100, 10, 10, 1'b0, 0, 0};
    vecs[5]  = '{-300, 0, -300, -50, 50, 25, 8, 8, 1'b1, 0, 2};
    vecs[6]  = '{5, 5, 0, 0, 0, 100, 10, 10, 1'b0, 0, 0};
    vecs[7]  = '{5, 5, 0, 0, 100, 100, 10, 0, 1'b0, 0, 0};
    vecs[8]  = '{2147483647, 0, -32768, 0, 65535, 1, 31, 31, 1'b0, 0, 0};
    vecs[9]  = '{3099, 3000, 0, 0, 100, 100, 31, 31, 1'b1, 30, 30};
    vecs[10] = '{100, 199, 0, 0, 100, 100, 10, 10, 1'b1, 1, 1};
    vecs[11] = '{-1, 5, -1, 10, 100, 100, 10, 10, 1'b0, 0, 0};

    foreach (model[k]) model[k] = 0;
    iq_valid = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_addr = '0;
    set_cfg('{0, 0, 0, 0, 100, 100, 10, 10, 1'b0, 0, 0});
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_drop", {16'd0, drop_count}, 32'd0);
    check("rst_oor", {16'd0, oor_count}, 32'd0);
    tick(3);
    reset_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    check("rst_clear_cycles", cnt, 1024);
    read_all();

    // Table of single events: latency bound, oor accounting, bin contents.
    for (int n = 0; n < 12; n++) begin
      v = vecs[n];
      send(v, $sformatf("vec%0d", n), cnt);
      if (v.in_rng) begin
        bound = ((v.ex > v.ey) ? v.ex : v.ey) + 3;
        check($sformatf("vec%0d_latency_ok", n), {31'd0, cnt <= bound}, 32'd1);
        addr = v.ey * 32 + v.ex;
        model[addr]++;
        read_bin(addr);
      end else begin
`ifdef IQ_BINNER_OOR_COUNT_EN
        exp_oor++;
`endif
      end
      check($sformatf("vec%0d_oor_count", n), {16'd0, oor_count}, exp_oor);
    end
    check("drop_after_vectors", {16'd0, drop_count}, exp_drop);

    // clear and iq_valid together: clear wins, the sample is the one drop.
    set_cfg(vecs[2]);
    clear = 1'b1; iq_valid = 1'b1;
    tick(1);
    clear = 1'b0; iq_valid = 1'b0;
    foreach (model[k]) model[k] = 0;
    exp_drop = 1;
    exp_oor = 0;
    check("clear_drop", {16'd0, drop_count}, exp_drop);
    check("clear_oor", {16'd0, oor_count}, 32'd0);
    check("clear_busy", {31'd0, busy}, 32'd1);
    wait_idle("clear", 1100, cnt);
    read_bin(290);
    read_bin(990);

    // Saturation: 20 hits on bin {0,0}; 4-bit copy must stick at 15.
    for (int h = 0; h < 20; h++) begin
      send(vecs[2], "sat_hit", cnt);
      model[0]++;
    end
    read_bin(0);
    read_narrow(0, 15);

    // Second sample two cycles into a long search is dropped.
    set_cfg('{550, 550, 0, 0, 100, 100, 10, 10, 1'b1, 5, 5});
    iq_valid = 1'b1;
    tick(1);
    iq_valid = 1'b0;
    tick(1);
    set_cfg(vecs[2]);
    iq_valid = 1'b1;
    tick(1);
    iq_valid = 1'b0;
    exp_drop++;
    wait_idle("drop", 40, cnt);
    model[5 * 32 + 5]++;
    check("drop_count", {16'd0, drop_count}, exp_drop);
    read_bin(5 * 32 + 5);
    read_bin(0);
    read_all();

    // Reset in the middle of a search: event abandoned, bins re-cleared.
    read_bin(0);
    set_cfg('{950, 950, 0, 0, 100, 100, 10, 10, 1'b1, 9, 9});
    iq_valid = 1'b1;
    tick(1);
    iq_valid = 1'b0;
    tick(3);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("midrst_rd_data", {16'd0, rd_data}, 32'd0);
    check("midrst_drop", {16'd0, drop_count}, 32'd0);
    check("midrst_oor", {16'd0, oor_count}, 32'd0);
    tick(1);
    reset_n = 1'b1;
    foreach (model[k]) model[k] = 0;
    exp_drop = 0;
    cnt = 0;
    while (busy && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    check("midrst_clear_cycles", cnt, 1024);
    read_bin(9 * 32 + 9);
    read_bin(0);

    tick(2);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
